out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Per-output-port wormhole arbiter for the 2x2 mesh router. It takes requests from the five input ports (N, E, W, S, L) that target this output and grants one of them round-robin. The grant is held until that packet's tail flit has transferred. The registered one-hot grant drives the crossbar select for this output directly. The block also generates the read strobes for the input FIFOs and the output flit-valid.

## Interface
Parameters:
- NPORTS, 5, number of requesters; fixed at 5. Bit order is 0=N, 1=E, 2=W, 3=S, 4=L.
- RST_PTR, 0, index of the highest-priority port after reset.

Ports:
- clk  input  1  router clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  5  req[i]=1: input FIFO i is non-empty and its head flit is routed to this output.
- tail  input  5  tail[i]=1: the head flit of input FIFO i is a tail flit. A single-flit packet sets header and tail together.
- out_ready  input  1  downstream can accept one flit this cycle.
- sel_out  output  5  one-hot crossbar select (00001=N, 00010=E, 00100=W, 01000=S, 10000=L); 00000 when idle. Registered.
- pop  output  5  read strobe to input FIFO i. pop = sel_out & req & {5{out_ready}}. Combinational.
- out_valid  output  1  equals |pop; a flit is on the crossbar output this cycle.
- busy  output  1  1 while state is BUSY. Registered.

## Operation
- State machine with two states:
  - IDLE: sel_out=0.
  - BUSY: sel_out holds the one-hot grant g.
- Round-robin pointer ptr is 3 bits, range 0..4.
- Combinational winner w: the first i with req[i]=1, scanning ptr, ptr+1, ... mod 5.
  - Wrap-around: index 4 is followed by 0.
  - has_w is 1 when req is non-zero.
- IDLE:
  - If has_w, then next sel_out=onehot(w) and next state is BUSY.
  - Otherwise stay in IDLE.
- BUSY, no tail transfer this cycle (pop[g]=0, or tail[g]=0): hold sel_out.
  - req[g] dropping mid-packet (FIFO underrun) does not release the grant.
- BUSY, tail transfer this cycle (pop[g]=1 and tail[g]=1):
  - ptr <= (g+1) mod 5.
  - Re-arbitrate in the same cycle using the updated pointer value, i.e. scan from (g+1) mod 5 and exclude g.
  - If another port requests, next sel_out=onehot(w') and stay BUSY.
  - Otherwise next sel_out=0 and go to IDLE.
  - The completing port g cannot win back-to-back while any other port requests. If only g requests, it is re-granted.
- ptr changes only on tail transfer, never on grant.
- out_ready=0 freezes everything: no pop, no state or pointer change.
- sel_out is guaranteed one-hot or zero at all times.

## Timing
- Reset (rst_n low, asynchronous): sel_out=00000, busy=0, ptr=RST_PTR, state=IDLE.
  - Combinational outputs follow: pop=00000, out_valid=0.
  - Reset mid-packet aborts the packet immediately. No partial-packet recovery is done here.
- Grant latency: req asserted in cycle 0 while IDLE → sel_out valid in cycle 1. The first pop can occur in cycle 1 if out_ready=1.
- Throughput: one flit per cycle while out_ready=1 and req[g]=1.
- Back-to-back packets: tail popped in cycle n → next grant visible in cycle n+1. There is no idle bubble on the grant.
- pop and out_valid are combinational from registered sel_out plus the current req and out_ready. There is no combinational path from req to sel_out.

## Test plan
- Reset then single request:
  - Stimulus: rst_n low for 2 cycles, then req=00100, tail=00000, out_ready=1.
  - Response: sel_out=00000 during reset; sel_out=00100 one cycle after req; pop=00100 every cycle; hold through 3 body flits.
  - Then tail=00100: on the tail pop, ptr=3; next cycle sel_out=00000 and busy=0.
- Round-robin fairness:
  - Stimulus: req=11111 constantly, all packets 2 flits, starting from ptr=0.
  - Response: grant order N,E,W,S,L,N as sel_out=00001,00010,00100,01000,10000,00001. Each change occurs the cycle after the tail pop, with no idle cycle.
- Wrap-around:
  - Stimulus: ptr=4, req=10001.
  - Response: L is granted first. After L's tail, N is granted (ptr 4→0). After N's tail with req=10001, L is granted again.
- Backpressure:
  - Stimulus: grant to E, out_ready=0 for 4 cycles, including during the tail flit.
  - Response: pop=00000 and out_valid=0 for those cycles; sel_out=00010 held; no pointer or state change.
- Underrun:
  - Stimulus: grant to S mid-packet; req[3]=0 for 3 cycles while req[0]=1.
  - Response: sel_out=01000 held, pop=00000. N is not granted until S's tail has transferred.
- Reset mid-packet:
  - Stimulus: rst_n asserted while sel_out=00010 with body flits pending.
  - Response: sel_out=00000 and pop=00000 immediately, without waiting for a clock edge; ptr=RST_PTR.

Source files
------------

// File: rtl/out_port_arbiter.sv
// out_port_arbiter
// Wormhole output-port arbiter for one output of the 2x2 mesh router.
// Five input ports (bit order 0=N, 1=E, 2=W, 3=S, 4=L) request this output.
// One of them is granted round-robin, and the grant is held until that
// packet's tail flit has transferred.
//
// Ports:
//   clk        router clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        req[i]: FIFO i is non-empty and its head flit targets this output
//   tail       tail[i]: head flit of FIFO i is a tail flit
//   out_ready  downstream accepts one flit this cycle
//   sel_out    registered one-hot crossbar select, zero when idle
//   pop        FIFO read strobes (combinational)
//   out_valid  a flit is on the crossbar output this cycle
//   busy       registered, high while a packet owns the output
//   dbg_state  FSM state (0=IDLE, 1=BUSY)
//   dbg_ptr    round-robin pointer
//
// Handshake: a flit moves from input FIFO g to the output in any cycle where
// sel_out[g] & req[g] & out_ready is high. That same cycle pop[g] is the FIFO
// read and out_valid marks the flit for the downstream. Nothing else advances
// a packet, and with out_ready low nothing in this block changes state.
module out_port_arbiter #(
  parameter int NPORTS  = 5,
  parameter int RST_PTR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] tail,
  input  logic              out_ready,
  output logic [NPORTS-1:0] sel_out,
  output logic [NPORTS-1:0] pop,
  output logic              out_valid,
  output logic              busy,
  output logic              dbg_state,
  output logic [2:0]        dbg_ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  g_idx;   // index of the current grant; sel_out is its one-hot form

  logic              tail_xfer;
  logic [2:0]        nxt_ptr;
  logic [2:0]        scan_start;
  logic [NPORTS-1:0] scan_req;
  logic              has_w;
  logic [2:0]        w_idx;
  logic [3:0]        idx;

  // sel_out is zero outside BUSY, so masking by it limits pop to the granted port.
  assign pop       = sel_out & req & {NPORTS{out_ready}};
  assign out_valid = |pop;
  assign dbg_state = (state == BUSY);
  assign dbg_ptr   = ptr;

  // pop is one-hot or zero, so this is pop[g] & tail[g].
  assign tail_xfer = |(pop & tail);
  assign nxt_ptr   = (g_idx == 3'd4) ? 3'd0 : g_idx + 3'd1;

  // Winner search. On a tail transfer the scan starts from the pointer value
  // being written this cycle and the finishing port is masked out. That way
  // another requester can take over without a bubble, and the finishing port
  // cannot win back-to-back.
  always_comb begin
    scan_start = tail_xfer ? nxt_ptr : ptr;
    scan_req   = tail_xfer ? (req & ~sel_out) : req;
    has_w      = 1'b0;
    w_idx      = 3'd0;
    idx        = 4'd0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = {1'b0, scan_start} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!has_w && scan_req[idx]) begin
        has_w = 1'b1;
        w_idx = idx[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_out <= '0;
      g_idx   <= 3'd0;
      ptr     <= 3'(RST_PTR);
      busy    <= 1'b0;
    end else if (out_ready) begin
      case (state)
        IDLE: begin
          if (has_w) begin
            state   <= BUSY;
            sel_out <= NPORTS'(1) << w_idx;
            g_idx   <= w_idx;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          // A dropped req[g] mid-packet is an underrun, so the grant is held
          // and only a tail transfer can release it.
          if (tail_xfer) begin
            ptr <= nxt_ptr;
            if (has_w) begin
              sel_out <= NPORTS'(1) << w_idx;
              g_idx   <= w_idx;
            end else begin
              state   <= IDLE;
              sel_out <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sel_out <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
module tb_out_port_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] tail;
  logic       out_ready;
  logic [4:0] sel_out;
  logic [4:0] pop;
  logic       out_valid;
  logic       busy;
  logic       dbg_state;
  logic [2:0] dbg_ptr;

  always #5 clk = ~clk;

  out_port_arbiter #(.NPORTS(5), .RST_PTR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .sel_out   (sel_out),
    .pop       (pop),
    .out_valid (out_valid),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  // Each entry is one expected output flit: {is_tail, one-hot source port}.
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- input FIFO model ----------------
  int         pkt_len [5][16];
  int         rd_ptr  [5];
  int         wr_ptr  [5];
  int         consumed[5];
  logic [4:0] hold;     // forces req low to model an upstream underrun

  task automatic flush_model();
    for (int p = 0; p < 5; p++) begin
      rd_ptr[p] = 0; wr_ptr[p] = 0; consumed[p] = 0;
    end
    hold = '0;
    exp_q.delete();
  endtask

  // Packets must be loaded in the order the arbiter is expected to serve them.
  task automatic load_pkt(input int p, input int len);
    logic [4:0] oh;
    oh = 5'b00001 << p;
    pkt_len[p][wr_ptr[p]] = len;
    wr_ptr[p]++;
    for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), oh});
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < 5; p++) begin
      if (rd_ptr[p] != wr_ptr[p]) begin
        req[p]  = ~hold[p];
        tail[p] = ((pkt_len[p][rd_ptr[p]] - consumed[p]) == 1);
      end else begin
        req[p]  = 1'b0;
        tail[p] = 1'b0;
      end
    end
  endtask

  // ---------------- driver / monitor ----------------
  // One clock: drive at posedge+1, observe at negedge, retire FIFO reads at posedge.
  task automatic tick();
    logic [4:0] popped;
    logic [5:0] e;
    drive_inputs();
    @(negedge clk);
    popped = pop;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_flit", {27'd0, pop}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("flit", {26'd0, |(pop & tail), pop}, {26'd0, e});
      end
    end
    @(posedge clk);
    for (int p = 0; p < 5; p++) begin
      if (popped[p] && rd_ptr[p] != wr_ptr[p]) begin
        consumed[p]++;
        if (consumed[p] == pkt_len[p][rd_ptr[p]]) begin
          consumed[p] = 0;
          rd_ptr[p]++;
        end
      end
    end
    #1;
  endtask

  // A cycle in which no flit may move and the grant and pointer must hold.
  task automatic stall_tick(input string tag, input logic [4:0] exp_sel, input logic [2:0] exp_ptr);
    drive_inputs();
    @(negedge clk);
    check_val({tag, "_pop"}, {27'd0, pop}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_sel"}, {27'd0, sel_out}, {27'd0, exp_sel});
    check_val({tag, "_ptr"}, {29'd0, dbg_ptr}, {29'd0, exp_ptr});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check_val({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag, input logic [2:0] exp_ptr);
    check_val({tag, "_sel"}, {27'd0, sel_out}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    check_val({tag, "_ptr"}, {29'd0, dbg_ptr}, {29'd0, exp_ptr});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_model();
    req = '0; tail = '0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("rst_sel", {27'd0, sel_out}, 32'd0);
      check_val("rst_pop", {27'd0, pop}, 32'd0);
      check_val("rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_ptr", {29'd0, dbg_ptr}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  int cyc;

  initial begin
    do_reset();

    // Single request on W: header, 3 body flits, tail.
    load_pkt(2, 5);
    drive_inputs();
    #1;
    check_val("lat0_sel", {27'd0, sel_out}, 32'd0);
    check_val("lat0_pop", {27'd0, pop}, 32'd0);
    tick();
    check_val("lat1_sel", {27'd0, sel_out}, 32'b00100);
    check_val("lat1_pop", {27'd0, pop}, 32'b00100);
    check_val("lat1_busy", {31'd0, busy}, 32'd1);
    drain("single_w", 20, cyc);
    check_val("single_w_cycles", cyc, 32'd5);
    check_idle("single_w_end", 3'd3);

    // One S packet moves the pointer to 4 for the wrap-around case.
    load_pkt(3, 2);
    drain("single_s", 20, cyc);
    check_idle("single_s_end", 3'd4);

    // Wrap-around: L, then N (ptr 4 -> 0), then L again.
    load_pkt(4, 2);
    load_pkt(0, 2);
    load_pkt(4, 2);
    drain("wrap", 30, cyc);
    check_val("wrap_cycles", cyc, 32'd7);
    check_idle("wrap_end", 3'd0);

    // Round-robin with every port always requesting, 2-flit packets.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 5; p++) load_pkt(p, 2);
    drain("rr", 100, cyc);
    check_val("rr_cycles", cyc, 32'd31);
    check_idle("rr_end", 3'd0);

    // Backpressure on E, stalling with the tail flit at the head.
    load_pkt(1, 2);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall_tick("bp", 5'b00010, 3'd0);
      check_val("bp_busy", {31'd0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    drain("bp", 10, cyc);
    check_idle("bp_end", 3'd2);

    // Underrun on S while N waits; N only after S's tail, with no bubble.
    load_pkt(3, 4);
    tick();
    check_val("ur_grant", {27'd0, sel_out}, 32'b01000);
    tick();
    hold[3] = 1'b1;
    load_pkt(0, 1);
    for (int i = 0; i < 3; i++) stall_tick("ur", 5'b01000, 3'd2);
    hold[3] = 1'b0;
    drain("ur", 20, cyc);
    check_val("ur_cycles", cyc, 32'd4);
    check_idle("ur_end", 3'd1);

    // Reset mid-packet on E: outputs clear without a clock edge.
    load_pkt(1, 5);
    tick();
    tick();
    check_val("mid_sel_before", {27'd0, sel_out}, 32'b00010);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sel", {27'd0, sel_out}, 32'd0);
    check_val("mid_rst_pop", {27'd0, pop}, 32'd0);
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_ptr", {29'd0, dbg_ptr}, 32'd0);
    flush_model();
    drive_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
